// File: rtl/divisor_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state codes and
// state-register width.
package divisor_seq_pkg;

  localparam int STATE_W = 3;

  // State codes are part of the external contract (visible on STATE_OUT and
  // NEXT_OUT), so they are fixed constants rather than a tool-encoded enum.
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_CALC = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd3;

endpackage

// File: rtl/divisor_seq_if.sv
// Bus bundle for divisor_seq: start request, operands, results and the
// observable internal state.
interface divisor_seq_if
  import divisor_seq_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic               en;
  logic [WIDTH-1:0]   A_IN;
  logic [WIDTH-1:0]   B_IN;
  logic [WIDTH-1:0]   Q_OUT;
  logic [WIDTH-1:0]   R_OUT;
  logic [WIDTH-1:0]   A_REG;
  logic [WIDTH-1:0]   B_REG;
  logic [STATE_W-1:0] STATE_OUT;
  logic [STATE_W-1:0] NEXT_OUT;
  logic [WIDTH-1:0]   COUNT_OUT;
  logic               COUNT_MAX;

  // Requester side: drives the start request and operands.
  modport master (
    output en, A_IN, B_IN,
    input  Q_OUT, R_OUT, A_REG, B_REG, STATE_OUT, NEXT_OUT, COUNT_OUT, COUNT_MAX
  );

  // Divider side.
  modport slave (
    input  en, A_IN, B_IN,
    output Q_OUT, R_OUT, A_REG, B_REG, STATE_OUT, NEXT_OUT, COUNT_OUT, COUNT_MAX
  );

endinterface

// File: rtl/divisor_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module divisor_step
  import divisor_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] a_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             neg;

  // The top bit of rem is never set before the last shift because the partial
  // remainder is bounded by the dividend bits consumed so far, so dropping
  // rem[WIDTH-1] is lossless. The extra trial bit is the borrow/sign.
  always_comb begin
    shifted = {rem_i[WIDTH-2:0], a_i[WIDTH-1]};
    trial   = {1'b0, shifted} - {1'b0, b_i};
    neg     = trial[WIDTH];
    rem_o   = neg ? shifted : trial[WIDTH-1:0];
    a_o     = {a_i[WIDTH-2:0], ~neg};
  end

endmodule

// File: rtl/divisor_seq.sv
// Sequential unsigned restoring divider: IDLE -> LOAD -> WIDTH x CALC -> DONE.
// Quotient is accumulated in the dividend shift register A_REG.
// WIDTH must be at least 2.
module divisor_seq
  import divisor_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  divisor_seq_if.slave  bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_a;
  logic               cnt_max;

  divisor_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .rem_o (step_rem),
    .a_o   (step_a)
  );

  assign cnt_max = (cnt_q == WIDTH'(WIDTH - 1));

  // Next-state logic; reset forces IDLE so NEXT_OUT reflects it immediately.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = bus.en ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_CALC;
      ST_CALC: state_d = cnt_max ? ST_DONE : ST_CALC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rst) state_d = ST_IDLE;
  end

  // Datapath and result updates selected by the current state.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    res_d = res_q;
    case (state_q)
      ST_LOAD: begin
        a_d   = bus.A_IN;
        b_d   = bus.B_IN;
        rem_d = '0;
        cnt_d = '0;
      end
      ST_CALC: begin
        a_d   = step_a;
        rem_d = step_rem;
        cnt_d = cnt_q + WIDTH'(1);
      end
      ST_DONE: begin
        quo_d = a_q;
        res_d = rem_q;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any
  // division in progress without publishing its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
    end
  end

  assign bus.Q_OUT     = quo_q;
  assign bus.R_OUT     = res_q;
  assign bus.A_REG     = a_q;
  assign bus.B_REG     = b_q;
  assign bus.STATE_OUT = state_q;
  assign bus.NEXT_OUT  = state_d;
  assign bus.COUNT_OUT = cnt_q;
  assign bus.COUNT_MAX = cnt_max;

endmodule

// File: tb/tb_divisor_seq.sv
// Bench for divisor_seq (WIDTH=4): scoreboard of expected results with the
// cycle on which each must appear, plus directed state/counter/reset checks.
module tb_divisor_seq;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  divisor_seq_if #(.WIDTH(W)) bus ();

  divisor_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference division, independent of the restoring algorithm.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.due = due;
    return e;
  endfunction

  // Results must appear exactly on their due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc >= sb[0].due) begin
      exp_t e;
      e = sb.pop_front();
      check("q_out", bus.Q_OUT, e.q);
      check("r_out", bus.R_OUT, e.r);
    end
  end

  // Start one division from IDLE; optionally toggle en while it runs and
  // scramble the operand inputs once they have been latched.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic noise);
    @(posedge clk); #1;
    bus.A_IN = a;
    bus.B_IN = b;
    bus.en   = 1'b1;
    sb.push_back(model(a, b, cyc + 7));
    @(posedge clk); #1;
    bus.en = noise;
    @(posedge clk); #1;
    bus.A_IN = W'($urandom);
    bus.B_IN = W'($urandom);
    repeat (4) @(posedge clk);
    #1 bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  int st_tab[7]  = '{1, 2, 2, 2, 2, 3, 0};
  int cnt_tab[7] = '{0, 0, 1, 2, 3, 4, 4};
  int max_tab[7] = '{0, 0, 0, 0, 1, 0, 0};

  initial begin
    bus.en   = 1'b1;
    bus.A_IN = 4'd7;
    bus.B_IN = 4'd3;

    // Reset with en asserted: reset wins.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", bus.STATE_OUT, 0);
    check("rst_next",  bus.NEXT_OUT, 0);
    check("rst_q",     bus.Q_OUT, 0);
    check("rst_r",     bus.R_OUT, 0);
    check("rst_areg",  bus.A_REG, 0);
    check("rst_breg",  bus.B_REG, 0);
    check("rst_count", bus.COUNT_OUT, 0);
    rst    = 1'b0;
    bus.en = 1'b0;
    repeat (2) @(posedge clk);

    // 3/2 with state, counter and COUNT_MAX trace.
    #1;
    bus.A_IN = 4'd3;
    bus.B_IN = 4'd2;
    bus.en   = 1'b1;
    check("seq_idle", bus.STATE_OUT, 0);
    check("seq_next", bus.NEXT_OUT, 1);
    sb.push_back(model(4'd3, 4'd2, cyc + 7));
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k == 0) bus.en = 1'b0;
      check($sformatf("seq_state%0d", k), bus.STATE_OUT, st_tab[k]);
      check($sformatf("seq_count%0d", k), bus.COUNT_OUT, cnt_tab[k]);
      check($sformatf("seq_max%0d", k),   bus.COUNT_MAX, max_tab[k]);
    end
    @(negedge clk);

    // Operand changes with en low do nothing; results hold.
    bus.A_IN = 4'd13;
    bus.B_IN = 4'd5;
    repeat (8) @(posedge clk);
    #1;
    check("hold_q", bus.Q_OUT, 1);
    check("hold_r", bus.R_OUT, 1);
    check("hold_state", bus.STATE_OUT, 0);
    do_op(4'd13, 4'd5, 1'b0);

    // Divide by zero, with en chatter during the operation.
    do_op(4'd9, 4'd0, 1'b1);

    // Reset in the middle of CALC.
    @(posedge clk); #1;
    bus.A_IN = 4'd5;
    bus.B_IN = 4'd2;
    bus.en   = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_calc", bus.STATE_OUT, 2);
    rst = 1'b1;
    #1;
    check("mid_next", bus.NEXT_OUT, 0);
    @(posedge clk); #1;
    check("mid_state", bus.STATE_OUT, 0);
    check("mid_q", bus.Q_OUT, 0);
    check("mid_r", bus.R_OUT, 0);
    check("mid_count", bus.COUNT_OUT, 0);
    rst = 1'b0;
    @(posedge clk);

    // Operand corners, plus a few random operands.
    do_op(4'd15, 4'd1, 1'b0);
    do_op(4'd2,  4'd7, 1'b1);
    do_op(4'd0,  4'd3, 1'b0);
    do_op(4'd14, 4'd15, 1'b0);
    for (int i = 0; i < 4; i++) do_op(W'($urandom), W'($urandom), 1'b0);

    // en held high across three operations: one result every 7 cycles.
    @(posedge clk); #1;
    bus.A_IN = 4'd6;
    bus.B_IN = 4'd4;
    bus.en   = 1'b1;
    sb.push_back(model(4'd6, 4'd4, cyc + 7));
    repeat (2) @(posedge clk);
    #1;
    bus.A_IN = 4'd11;
    bus.B_IN = 4'd2;
    sb.push_back(model(4'd11, 4'd2, cyc + 12));
    repeat (7) @(posedge clk);
    #1;
    bus.A_IN = 4'd8;
    bus.B_IN = 4'd0;
    sb.push_back(model(4'd8, 4'd0, cyc + 12));
    repeat (6) @(posedge clk);
    #1;
    bus.en = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 100 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) check("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("final_state", bus.STATE_OUT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/divisor_seq.md
DIVISOR_SEQ -- requirements
Module: divisor_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, giving the operand, quotient, remainder and counter width; WIDTH SHALL be at least 2.
REQ-002 clk  input  1  Single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  Reset; synchronous and active-high.
REQ-004 en  input  1  Start request, sampled only in IDLE.
REQ-005 A_IN  input  WIDTH  Unsigned dividend.
REQ-006 B_IN  input  WIDTH  Unsigned divisor.
REQ-007 Q_OUT  output  WIDTH  Registered quotient of the last completed division.
REQ-008 R_OUT  output  WIDTH  Registered remainder of the last completed division.
REQ-009 A_REG  output  WIDTH  Working dividend/quotient shift register.
REQ-010 B_REG  output  WIDTH  Latched divisor.
REQ-011 STATE_OUT  output  3  Current state code.
REQ-012 NEXT_OUT  output  3  Combinational next-state code.
REQ-013 COUNT_OUT  output  WIDTH  Iteration counter.
REQ-014 COUNT_MAX  output  1  Combinational flag, high when COUNT_OUT equals WIDTH-1.

Function
REQ-015 State codes SHALL be IDLE=0, LOAD=1, CALC=2, DONE=3; codes 4-7 are illegal and SHALL go to IDLE next cycle.
REQ-016 IDLE SHALL go to LOAD when en=1; otherwise it SHALL stay in IDLE.
REQ-017 LOAD SHALL latch A_REG<=A_IN and B_REG<=B_IN, clear the internal WIDTH-bit partial remainder and COUNT_OUT, and go to CALC.
REQ-018 Each CALC cycle SHALL perform one restoring step, using a WIDTH+1-bit trial: trial = {rem[WIDTH-2:0], A_REG[WIDTH-1]} - B_REG.
REQ-019 If the trial is non-negative, the CALC step SHALL set rem<=trial and shift A_REG left with LSB 1.
REQ-020 If the trial is negative, the CALC step SHALL set rem<={rem[WIDTH-2:0], A_REG[WIDTH-1]} and shift A_REG left with LSB 0.
REQ-021 Each CALC cycle SHALL increment COUNT_OUT.
REQ-022 CALC SHALL go to DONE on the cycle in which COUNT_MAX=1, giving exactly WIDTH iterations.
REQ-023 DONE SHALL load Q_OUT<=A_REG and R_OUT<=rem and go to IDLE.
REQ-024 Latency: if en is sampled at edge E0, Q_OUT/R_OUT SHALL update at edge E0+WIDTH+2 (6 edges for WIDTH=4).
REQ-025 Q_OUT/R_OUT SHALL hold their values until the next DONE.
REQ-026 Input changes outside LOAD SHALL have no effect.
REQ-027 en SHALL be ignored in LOAD, CALC and DONE.
REQ-028 If en is held high, a new operation SHALL start from IDLE each time.
REQ-029 For B=0, the result SHALL be Q_OUT=all ones and R_OUT=A (natural restoring result); no error flag.
REQ-030 Arithmetic SHALL be unsigned, with no overflow possible in Q or R.

Reset
REQ-031 While rst=1 at a clock edge, the state SHALL become IDLE.
REQ-032 While rst=1 at a clock edge, Q_OUT, R_OUT, A_REG, B_REG, COUNT_OUT and rem SHALL be cleared to 0.
REQ-033 NEXT_OUT SHALL read IDLE while rst=1.
REQ-034 Reset SHALL take priority over en.
REQ-035 Reset SHALL abort any in-progress division without updating Q_OUT/R_OUT from it.

Structure
REQ-036 State encodings SHALL reside in a shared package divisor_seq_pkg.
REQ-037 The combinational one-iteration shift/subtract step SHALL be a sub-module divisor_step (inputs rem, A_REG, B_REG; outputs new rem, new A_REG).
REQ-038 The FSM, counter and output registers SHALL be in the top module.

Verification
REQ-039 Reset sequence: rst then A=3,B=2 with a 1-cycle en pulse -> STATE_OUT sequence 0,1,2,2,2,2,3,0; Q_OUT=1, R_OUT=1 six edges after en.
REQ-040 Input-hold sequence: after REQ-039, A=13,B=5 with en=0 -> Q/R stay 1/1; then pulse en -> Q=2, R=3.
REQ-041 Divide-by-zero: A=9,B=0 -> Q=15, R=9.
REQ-042 Operand corners: A=15,B=1 -> Q=15, R=0; A=2,B=7 -> Q=0, R=2; A=0,B=3 -> Q=0, R=0.
REQ-043 Reset mid-operation: rst during CALC -> next state 0, Q/R/COUNT_OUT=0; en pulses during CALC have no effect on sequence or result.
REQ-044 COUNT_MAX check: COUNT_MAX high only when COUNT_OUT=3 (WIDTH=4).
REQ-045 Continuous en: en held high for three operations -> each result appears every 7 cycles.
